// File: rtl/bpu_gshare.sv
// Fetch-block branch predictor: typed set-associative BTB, gshare BHT and a speculative circular RAS.
// Define BPU_PERF_CNT_EN to add the perf_lookup_o / perf_redirect_o event counters.
module bpu_gshare #(
  parameter int PLEN            = 32,
  parameter int INSTR_PER_FETCH = 4,
  parameter int BTB_SETS        = 32,
  parameter int BTB_WAYS        = 2,
  parameter int BHT_ENTRIES     = 512,
  parameter int GHR_W           = 8,
  parameter int RAS_DEPTH       = 16,
  localparam int PW     = $clog2(RAS_DEPTH),
  localparam int CW     = $clog2(RAS_DEPTH + 1),
  localparam int SW     = $clog2(INSTR_PER_FETCH),
  localparam int CKPT_W = GHR_W + CW + PW + PLEN
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fetch_valid_i,
  input  logic [PLEN-1:0]   fetch_pc_i,
  output logic              fetch_ready_o,
  output logic              pred_valid_o,
  input  logic              pred_ready_i,
  output logic              pred_slot_valid_o,
  output logic [SW-1:0]     pred_slot_idx_o,
  output logic [PLEN-1:0]   pred_npc_o,
  output logic [CKPT_W-1:0] pred_ckpt_o,
  input  logic              redirect_valid_i,
  input  logic [CKPT_W-1:0] redirect_ckpt_i,
  input  logic              redirect_is_cond_i,
  input  logic              redirect_taken_i,
  input  logic              redirect_is_call_i,
  input  logic              redirect_is_ret_i,
  input  logic [PLEN-1:0]   redirect_pc_i,
  input  logic              update_valid_i,
  input  logic [PLEN-1:0]   update_pc_i,
  input  logic [1:0]        update_type_i,
  input  logic              update_taken_i,
  input  logic [PLEN-1:0]   update_target_i,
  input  logic [GHR_W-1:0]  update_ghr_i
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_lookup_o,
  output logic [31:0]       perf_redirect_o
`endif
);

  localparam int SETB  = $clog2(BTB_SETS);
  localparam int TAG_W = PLEN - 2 - SETB;
  localparam int BHTB  = $clog2(BHT_ENTRIES);
  localparam int VW    = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JUMP = 2'd1,
    BR_CALL = 2'd2,
    BR_RET  = 2'd3
  } br_type_e;

  logic [BTB_WAYS-1:0] btb_valid_reg  [BTB_SETS];
  logic [TAG_W-1:0]    btb_tag_reg    [BTB_SETS][BTB_WAYS];
  logic [1:0]          btb_type_reg   [BTB_SETS][BTB_WAYS];
  logic [PLEN-1:0]     btb_target_reg [BTB_SETS][BTB_WAYS];
  logic [VW-1:0]       victim_reg     [BTB_SETS];
  logic [1:0]          bht_reg        [BHT_ENTRIES];
  logic [PLEN-1:0]     ras_reg        [RAS_DEPTH];
  logic [GHR_W-1:0]    ghr_reg, ghr_next;
  logic [PW-1:0]       ras_ptr_reg, ras_ptr_next;
  logic [CW-1:0]       ras_cnt_reg, ras_cnt_next;

  logic              pred_valid_reg, pred_slot_valid_reg;
  logic [SW-1:0]     pred_slot_idx_reg;
  logic [PLEN-1:0]   pred_npc_reg;
  logic [CKPT_W-1:0] pred_ckpt_reg;

  logic accept;
  assign fetch_ready_o = !redirect_valid_i && (!pred_valid_reg || pred_ready_i);
  assign accept        = fetch_valid_i && fetch_ready_o;

  // Per-slot BTB probe and gshare direction lookup
  logic                slot_hit   [INSTR_PER_FETCH];
  logic                slot_taken [INSTR_PER_FETCH];
  logic [1:0]          slot_type  [INSTR_PER_FETCH];
  logic [PLEN-1:0]     slot_tgt   [INSTR_PER_FETCH];

  for (genvar gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_slot
    logic [PLEN-1:0]  pc;
    logic [SETB-1:0]  set_idx;
    logic [TAG_W-1:0] tag;
    logic [BHTB-1:0]  bht_idx;
    logic             hit;
    logic [1:0]       btype;
    logic [PLEN-1:0]  tgt;
    logic             unused_pc_lo;

    assign pc           = fetch_pc_i + PLEN'(4 * gi);
    assign set_idx      = pc[2 +: SETB];
    assign tag          = pc[PLEN-1 -: TAG_W];
    assign bht_idx      = pc[2 +: BHTB] ^ BHTB'(ghr_reg);
    assign unused_pc_lo = ^pc[1:0];

    always_comb begin
      hit   = 1'b0;
      btype = BR_COND;
      tgt   = '0;
      for (int w = 0; w < BTB_WAYS; w++) begin
        if (btb_valid_reg[set_idx][w] && btb_tag_reg[set_idx][w] == tag) begin
          hit   = 1'b1;
          btype = btb_type_reg[set_idx][w];
          tgt   = btb_target_reg[set_idx][w];
        end
      end
    end

    assign slot_hit[gi]   = hit;
    assign slot_type[gi]  = btype;
    assign slot_tgt[gi]   = tgt;
    assign slot_taken[gi] = hit && (btype != BR_COND || bht_reg[bht_idx][1]);
  end

  logic          sel_found, sel_cond;
  logic [SW-1:0] sel_idx;
  always_comb begin
    sel_found = 1'b0;
    sel_cond  = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      if (!sel_found) begin
        if (slot_hit[i] && slot_type[i] == BR_COND) sel_cond = 1'b1;
        if (slot_taken[i]) begin
          sel_found = 1'b1;
          sel_idx   = SW'(i);
        end
      end
    end
  end

  logic [1:0]        sel_type;
  logic [PLEN-1:0]   sel_pc, lk_npc, ras_top;
  logic [PW-1:0]     ras_top_idx;
  logic [CKPT_W-1:0] cur_ckpt;

  assign sel_type    = slot_type[sel_idx];
  assign sel_pc      = fetch_pc_i + PLEN'({sel_idx, 2'b00});
  assign ras_top_idx = ras_ptr_reg - PW'(1);
  assign ras_top     = ras_reg[ras_top_idx];
  assign cur_ckpt    = {ghr_reg, ras_cnt_reg, ras_ptr_reg, ras_top};

  always_comb begin
    lk_npc = fetch_pc_i + PLEN'(4 * INSTR_PER_FETCH);
    if (sel_found) begin
      if (sel_type == BR_RET && ras_cnt_reg != '0) lk_npc = ras_top;
      else                                         lk_npc = slot_tgt[sel_idx];
    end
  end

  // Speculative state: redirect restores a checkpoint, an accepted lookup advances from the live state
  logic [GHR_W-1:0] rd_ghr;
  logic [CW-1:0]    rd_cnt;
  logic [PW-1:0]    rd_ptr;
  logic [PLEN-1:0]  rd_top;
  assign rd_ghr = redirect_ckpt_i[CKPT_W-1 -: GHR_W];
  assign rd_cnt = redirect_ckpt_i[PLEN+PW +: CW];
  assign rd_ptr = redirect_ckpt_i[PLEN +: PW];
  assign rd_top = redirect_ckpt_i[0 +: PLEN];

  logic [PW-1:0]   base_ptr, fix_addr, push_addr;
  logic [CW-1:0]   base_cnt;
  logic            do_call, do_ret, fix_we, push_we;
  logic [PLEN-1:0] push_data;

  always_comb begin
    ghr_next  = ghr_reg;
    base_ptr  = ras_ptr_reg;
    base_cnt  = ras_cnt_reg;
    do_call   = 1'b0;
    do_ret    = 1'b0;
    push_data = '0;
    fix_we    = 1'b0;
    fix_addr  = rd_ptr - PW'(1);
    if (redirect_valid_i) begin
      base_ptr  = rd_ptr;
      base_cnt  = rd_cnt;
      fix_we    = (rd_cnt != '0);
      ghr_next  = redirect_is_cond_i ? {rd_ghr[GHR_W-2:0], redirect_taken_i} : rd_ghr;
      do_call   = redirect_is_call_i;
      do_ret    = redirect_is_ret_i;
      push_data = redirect_pc_i + PLEN'(4);
    end else if (accept) begin
      if (sel_cond) ghr_next = {ghr_reg[GHR_W-2:0], sel_found};
      do_call   = sel_found && sel_type == BR_CALL;
      do_ret    = sel_found && sel_type == BR_RET;
      push_data = sel_pc + PLEN'(4);
    end
    ras_ptr_next = base_ptr;
    ras_cnt_next = base_cnt;
    push_we      = 1'b0;
    push_addr    = base_ptr;
    if (do_call) begin
      push_we      = 1'b1;
      ras_ptr_next = base_ptr + PW'(1);
      if (base_cnt != CW'(RAS_DEPTH)) ras_cnt_next = base_cnt + CW'(1);
    end else if (do_ret && base_cnt != '0) begin
      ras_ptr_next = base_ptr - PW'(1);
      ras_cnt_next = base_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ghr_reg     <= '0;
      ras_ptr_reg <= '0;
      ras_cnt_reg <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_reg[i] <= '0;
    end else begin
      ghr_reg     <= ghr_next;
      ras_ptr_reg <= ras_ptr_next;
      ras_cnt_reg <= ras_cnt_next;
      if (fix_we)  ras_reg[fix_addr]  <= rd_top;
      if (push_we) ras_reg[push_addr] <= push_data;
    end
  end

  // Commit-time training of BTB and BHT
  logic [SETB-1:0]  u_set;
  logic [TAG_W-1:0] u_tag;
  logic [BHTB-1:0]  u_bidx;
  logic             u_hit, btb_we, bht_we;
  logic [VW-1:0]    u_hit_way, u_way;
  logic [1:0]       u_ctr, u_ctr_next;
  logic             unused_upd;

  assign u_set      = update_pc_i[2 +: SETB];
  assign u_tag      = update_pc_i[PLEN-1 -: TAG_W];
  assign u_bidx     = update_pc_i[2 +: BHTB] ^ BHTB'(update_ghr_i);
  assign unused_upd = ^update_pc_i[1:0];
  assign btb_we     = update_valid_i && (update_type_i != BR_COND || update_taken_i);
  assign bht_we     = update_valid_i && update_type_i == BR_COND;
  assign u_ctr      = bht_reg[u_bidx];
  assign u_way      = u_hit ? u_hit_way : victim_reg[u_set];

  always_comb begin
    u_hit     = 1'b0;
    u_hit_way = '0;
    for (int w = 0; w < BTB_WAYS; w++) begin
      if (btb_valid_reg[u_set][w] && btb_tag_reg[u_set][w] == u_tag) begin
        u_hit     = 1'b1;
        u_hit_way = VW'(w);
      end
    end
    u_ctr_next = u_ctr;
    if (update_taken_i && u_ctr != 2'b11)       u_ctr_next = u_ctr + 2'b01;
    else if (!update_taken_i && u_ctr != 2'b00) u_ctr_next = u_ctr - 2'b01;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_reg[i] <= 2'b01;
    end else if (bht_we) begin
      bht_reg[u_bidx] <= u_ctr_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < BTB_SETS; s++) begin
        btb_valid_reg[s] <= '0;
        victim_reg[s]    <= '0;
        for (int w = 0; w < BTB_WAYS; w++) begin
          btb_tag_reg[s][w]    <= '0;
          btb_type_reg[s][w]   <= '0;
          btb_target_reg[s][w] <= '0;
        end
      end
    end else if (btb_we) begin
      btb_valid_reg[u_set][u_way]  <= 1'b1;
      btb_tag_reg[u_set][u_way]    <= u_tag;
      btb_type_reg[u_set][u_way]   <= update_type_i;
      btb_target_reg[u_set][u_way] <= update_target_i;
      if (!u_hit)
        victim_reg[u_set] <= (victim_reg[u_set] == VW'(BTB_WAYS - 1)) ? '0 : victim_reg[u_set] + VW'(1);
    end
  end

  // Prediction output register; a redirect drops whatever is held
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_valid_reg      <= 1'b0;
      pred_slot_valid_reg <= 1'b0;
      pred_slot_idx_reg   <= '0;
      pred_npc_reg        <= '0;
      pred_ckpt_reg       <= '0;
    end else if (redirect_valid_i) begin
      pred_valid_reg <= 1'b0;
    end else if (accept) begin
      pred_valid_reg      <= 1'b1;
      pred_slot_valid_reg <= sel_found;
      pred_slot_idx_reg   <= sel_idx;
      pred_npc_reg        <= lk_npc;
      pred_ckpt_reg       <= cur_ckpt;
    end else if (pred_ready_i) begin
      pred_valid_reg <= 1'b0;
    end
  end

  assign pred_valid_o      = pred_valid_reg;
  assign pred_slot_valid_o = pred_slot_valid_reg;
  assign pred_slot_idx_o   = pred_slot_idx_reg;
  assign pred_npc_o        = pred_npc_reg;
  assign pred_ckpt_o       = pred_ckpt_reg;

`ifdef BPU_PERF_CNT_EN
  logic [31:0] perf_lookup_reg, perf_redirect_reg;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_lookup_reg   <= '0;
      perf_redirect_reg <= '0;
    end else begin
      if (accept)           perf_lookup_reg   <= perf_lookup_reg + 32'd1;
      if (redirect_valid_i) perf_redirect_reg <= perf_redirect_reg + 32'd1;
    end
  end
  assign perf_lookup_o   = perf_lookup_reg;
  assign perf_redirect_o = perf_redirect_reg;
`endif

endmodule

// File: tb/tb_bpu_gshare.sv
// Directed bench for bpu_gshare: reset, BTB/BHT training, RAS push/pop and overflow, hold, redirect, set conflict.
module tb_bpu_gshare;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fetch_valid_i;
  logic [31:0] fetch_pc_i;
  logic        fetch_ready_o;
  logic        pred_valid_o;
  logic        pred_ready_i;
  logic        pred_slot_valid_o;
  logic [1:0]  pred_slot_idx_o;
  logic [31:0] pred_npc_o;
  logic [48:0] pred_ckpt_o;
  logic        redirect_valid_i;
  logic [48:0] redirect_ckpt_i;
  logic        redirect_is_cond_i, redirect_taken_i, redirect_is_call_i, redirect_is_ret_i;
  logic [31:0] redirect_pc_i;
  logic        update_valid_i;
  logic [31:0] update_pc_i;
  logic [1:0]  update_type_i;
  logic        update_taken_i;
  logic [31:0] update_target_i;
  logic [7:0]  update_ghr_i;
`ifdef BPU_PERF_CNT_EN
  logic [31:0] perf_lookup_o, perf_redirect_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bpu_gshare dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i), .fetch_ready_o(fetch_ready_o),
    .pred_valid_o(pred_valid_o), .pred_ready_i(pred_ready_i),
    .pred_slot_valid_o(pred_slot_valid_o), .pred_slot_idx_o(pred_slot_idx_o),
    .pred_npc_o(pred_npc_o), .pred_ckpt_o(pred_ckpt_o),
    .redirect_valid_i(redirect_valid_i), .redirect_ckpt_i(redirect_ckpt_i),
    .redirect_is_cond_i(redirect_is_cond_i), .redirect_taken_i(redirect_taken_i),
    .redirect_is_call_i(redirect_is_call_i), .redirect_is_ret_i(redirect_is_ret_i),
    .redirect_pc_i(redirect_pc_i),
    .update_valid_i(update_valid_i), .update_pc_i(update_pc_i), .update_type_i(update_type_i),
    .update_taken_i(update_taken_i), .update_target_i(update_target_i), .update_ghr_i(update_ghr_i)
`ifdef BPU_PERF_CNT_EN
    , .perf_lookup_o(perf_lookup_o), .perf_redirect_o(perf_redirect_o)
`endif
  );

  function automatic logic [48:0] ck(input logic [7:0] ghr, input logic [4:0] cnt,
                                     input logic [3:0] ptr, input logic [31:0] top);
    return {ghr, cnt, ptr, top};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic update(input logic [31:0] pc, input logic [1:0] typ, input logic taken,
                        input logic [31:0] tgt, input logic [7:0] ghr);
    @(negedge clk_i);
    update_valid_i = 1'b1; update_pc_i = pc; update_type_i = typ;
    update_taken_i = taken; update_target_i = tgt; update_ghr_i = ghr;
    @(posedge clk_i); #1;
    update_valid_i = 1'b0;
    $display("update pc=%h type=%0d taken=%0b target=%h ghr=%h", pc, typ, taken, tgt, ghr);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_sv,
                        input logic [1:0] exp_idx, input logic [31:0] exp_npc, input logic [48:0] exp_ckpt);
    @(negedge clk_i);
    fetch_valid_i = 1'b1; fetch_pc_i = pc; pred_ready_i = 1'b1;
    @(posedge clk_i); #1;
    fetch_valid_i = 1'b0;
    check({tag, ".valid"}, 64'(pred_valid_o), 64'(1'b1));
    check({tag, ".slot_valid"}, 64'(pred_slot_valid_o), 64'(exp_sv));
    if (exp_sv) check({tag, ".slot_idx"}, 64'(pred_slot_idx_o), 64'(exp_idx));
    check({tag, ".npc"}, 64'(pred_npc_o), 64'(exp_npc));
    check({tag, ".ckpt"}, 64'(pred_ckpt_o), 64'(exp_ckpt));
    $display("lookup %s pc=%h slot_valid=%0b idx=%0d npc=%h ckpt=%h",
             tag, pc, pred_slot_valid_o, pred_slot_idx_o, pred_npc_o, pred_ckpt_o);
  endtask

  task automatic redirect(input string tag, input logic [48:0] ckpt, input logic is_cond,
                          input logic taken, input logic is_call, input logic [31:0] pc);
    @(negedge clk_i);
    redirect_valid_i = 1'b1; redirect_ckpt_i = ckpt; redirect_is_cond_i = is_cond;
    redirect_taken_i = taken; redirect_is_call_i = is_call; redirect_is_ret_i = 1'b0;
    redirect_pc_i = pc; fetch_valid_i = 1'b1;
    #1 check({tag, ".fetch_ready"}, 64'(fetch_ready_o), 64'(1'b0));
    @(posedge clk_i); #1;
    redirect_valid_i = 1'b0; fetch_valid_i = 1'b0; pred_ready_i = 1'b1;
    check({tag, ".valid_dropped"}, 64'(pred_valid_o), 64'(1'b0));
    $display("redirect %s ckpt=%h cond=%0b taken=%0b call=%0b pc=%h", tag, ckpt, is_cond, taken, is_call, pc);
  endtask

  initial begin
    rst_ni = 1'b0; fetch_valid_i = 1'b0; fetch_pc_i = '0; pred_ready_i = 1'b1;
    redirect_valid_i = 1'b0; redirect_ckpt_i = '0; redirect_is_cond_i = 1'b0; redirect_taken_i = 1'b0;
    redirect_is_call_i = 1'b0; redirect_is_ret_i = 1'b0; redirect_pc_i = '0;
    update_valid_i = 1'b0; update_pc_i = '0; update_type_i = '0; update_taken_i = 1'b0;
    update_target_i = '0; update_ghr_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset.valid", 64'(pred_valid_o), 64'(1'b0));
    check("reset.slot_valid", 64'(pred_slot_valid_o), 64'(1'b0));
    check("reset.npc", 64'(pred_npc_o), 64'(32'h0));
    check("reset.ckpt", 64'(pred_ckpt_o), 64'(49'h0));
    check("reset.fetch_ready", 64'(fetch_ready_o), 64'(1'b1));
    @(negedge clk_i) rst_ni = 1'b1;

    lookup("empty", 32'h8000_0000, 1'b0, 2'd0, 32'h8000_0010, 49'h0);

    update(32'h8000_0008, 2'd1, 1'b1, 32'h8000_0100, 8'h00);
    lookup("jump", 32'h8000_0000, 1'b1, 2'd2, 32'h8000_0100, 49'h0);

    update(32'h8000_0004, 2'd2, 1'b1, 32'h8000_0200, 8'h00);
    update(32'h8000_0200, 2'd3, 1'b1, 32'hDEAD_0000, 8'h00);
    lookup("call", 32'h8000_0000, 1'b1, 2'd1, 32'h8000_0200, 49'h0);
    lookup("ret", 32'h8000_0200, 1'b1, 2'd0, 32'h8000_0008, ck(8'h00, 5'd1, 4'd1, 32'h8000_0008));

    update(32'h8000_0000, 2'd0, 1'b1, 32'h8000_0040, 8'h00);
    update(32'h8000_0000, 2'd0, 1'b1, 32'h8000_0040, 8'h00);
    lookup("cond_taken", 32'h8000_0000, 1'b1, 2'd0, 32'h8000_0040, 49'h0);
    lookup("ghr_shift", 32'h8000_0040, 1'b0, 2'd0, 32'h8000_0050, ck(8'h01, 5'd0, 4'd0, 32'h0));

    // With GHR=1 the slot-0 cond reads a weak-not-taken counter, so the call in slot 1 wins
    @(negedge clk_i) pred_ready_i = 1'b1;
    @(negedge clk_i);
    fetch_valid_i = 1'b1; fetch_pc_i = 32'h8000_0000; pred_ready_i = 1'b0;
    @(posedge clk_i); #1;
    fetch_pc_i = 32'h8000_0040;
    check("hold.accept_idx", 64'(pred_slot_idx_o), 64'(2'd1));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
      check("hold.valid", 64'(pred_valid_o), 64'(1'b1));
      check("hold.fetch_ready", 64'(fetch_ready_o), 64'(1'b0));
      check("hold.npc", 64'(pred_npc_o), 64'(32'h8000_0200));
      check("hold.ckpt", 64'(pred_ckpt_o), 64'(ck(8'h01, 5'd0, 4'd0, 32'h0)));
    end
    redirect("cond", ck(8'h05, 5'd0, 4'd0, 32'h0), 1'b1, 1'b1, 1'b0, 32'h8000_0000);
    lookup("ghr_restore", 32'h8000_0040, 1'b0, 2'd0, 32'h8000_0050, ck(8'h0B, 5'd0, 4'd0, 32'h0));

    for (int k = 0; k < 17; k++) begin
      lookup("ras_push", 32'h8000_0004, 1'b1, 2'd0, 32'h8000_0200,
             ck(8'h0B, (k > 16) ? 5'd16 : 5'(k), 4'(k), (k == 0) ? 32'h0 : 32'h8000_0008));
    end
    lookup("ras_full", 32'h8000_0200, 1'b1, 2'd0, 32'h8000_0008, ck(8'h0B, 5'd16, 4'd1, 32'h8000_0008));
    redirect("call", ck(8'h0B, 5'd16, 4'd1, 32'h8000_0008), 1'b0, 1'b0, 1'b1, 32'h9000_0000);
    lookup("redir_call_ret", 32'h8000_0200, 1'b1, 2'd0, 32'h9000_0004, ck(8'h0B, 5'd16, 4'd2, 32'h9000_0004));

    update(32'h1000_0014, 2'd1, 1'b1, 32'h0000_1000, 8'h00);
    update(32'h2000_0014, 2'd1, 1'b1, 32'h0000_2000, 8'h00);
    update(32'h3000_0014, 2'd1, 1'b1, 32'h0000_3000, 8'h00);
    lookup("evicted", 32'h1000_0014, 1'b0, 2'd0, 32'h1000_0024, ck(8'h0B, 5'd15, 4'd1, 32'h8000_0008));
    lookup("way1_kept", 32'h2000_0014, 1'b1, 2'd0, 32'h0000_2000, ck(8'h0B, 5'd15, 4'd1, 32'h8000_0008));
    lookup("way0_new", 32'h3000_0014, 1'b1, 2'd0, 32'h0000_3000, ck(8'h0B, 5'd15, 4'd1, 32'h8000_0008));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bpu_gshare.md
Name: bpu_gshare

Overview:
Second-generation fetch-block branch predictor. It sits between the IFU PC generator and the fetch queue. It combines three structures:
- a set-associative, typed BTB;
- a gshare BHT indexed by PC XOR a speculative global history register (GHR);
- a speculative circular RAS.

Every prediction carries a checkpoint of the speculative state. On a backend redirect that checkpoint is restored, with the resolving branch's outcome applied on top. Predictions are registered behind a valid/ready handshake.

Parameters:
- PLEN, 32, physical address width.
- INSTR_PER_FETCH, 4, instruction slots per fetch block. Slot i address = fetch_pc + 4*i.
- BTB_SETS, 32, number of BTB sets (power of 2).
- BTB_WAYS, 2, BTB associativity (power of 2).
- BHT_ENTRIES, 512, gshare 2-bit counters (power of 2).
- GHR_W, 8, global history bits (GHR_W <= log2(BHT_ENTRIES)).
- RAS_DEPTH, 16, RAS entries (power of 2).
- Derived:
  - PW = log2(RAS_DEPTH); CW = log2(RAS_DEPTH+1); SW = log2(INSTR_PER_FETCH).
  - CKPT_W = GHR_W + CW + PW + PLEN.
  - Checkpoint layout, MSB to LSB: {ghr, ras_cnt, ras_ptr, ras_top}.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- fetch_valid_i  in  1  lookup request.
- fetch_pc_i  in  PLEN  fetch block PC, 4-byte aligned.
- fetch_ready_o  out  1  lookup accepted.
- pred_valid_o  out  1  prediction valid.
- pred_ready_i  in  1  prediction consumed.
- pred_slot_valid_o  out  1  a slot is predicted taken.
- pred_slot_idx_o  out  SW  index of the first taken slot.
- pred_npc_o  out  PLEN  next fetch PC.
- pred_ckpt_o  out  CKPT_W  speculative state before this block's effects.
- redirect_valid_i  in  1  backend misprediction.
- redirect_ckpt_i  in  CKPT_W  checkpoint of the mispredicted block.
- redirect_is_cond_i  in  1  resolving instruction is conditional.
- redirect_taken_i  in  1  its actual direction.
- redirect_is_call_i  in  1  it is a call.
- redirect_is_ret_i  in  1  it is a return.
- redirect_pc_i  in  PLEN  its PC.
- update_valid_i  in  1  commit-time training.
- update_pc_i  in  PLEN  branch PC.
- update_type_i  in  2  branch type: 0=cond, 1=jump, 2=call, 3=ret.
- update_taken_i  in  1  actual direction.
- update_target_i  in  PLEN  actual target.
- update_ghr_i  in  GHR_W  GHR value used when the branch was predicted.

Behaviour:
- **Reset.**
  - pred_valid_o=0; all other pred_* outputs=0.
  - All BTB valid bits=0.
  - All BHT counters=2'b01.
  - GHR=0; ras_ptr=0; ras_cnt=0; RAS storage=0.
  - Victim pointers=0.
- **Handshake.**
  - fetch_ready_o = !redirect_valid_i && (!pred_valid_o || pred_ready_i).
  - A lookup is accepted on fetch_valid_i && fetch_ready_o. Its result appears on pred_* the next cycle (1-cycle latency).
  - pred_* is held stable while pred_valid_o && !pred_ready_i.
  - pred_valid_o clears when consumed without a new accept.
- **BTB lookup.**
  - Set index = slot_pc[2+:log2(BTB_SETS)]; tag = remaining upper bits.
  - Hit = any way of the set is valid with a matching tag. At most one way matches.
- **Slot direction.**
  - Hit type cond: taken when BHT[(slot_pc[2+:log2 BHT] XOR zero-extended GHR)][1] is set.
  - Hit types jump, call, ret: always taken.
- **First taken slot** wins.
  - Target = BTB target, except for ret with ras_cnt>0, which uses the RAS top.
  - Without a taken slot, pred_npc_o = fetch_pc + 4*INSTR_PER_FETCH.
- **Speculative update on accept.** pred_ckpt_o captures the state before these updates.
  - GHR shifts left by one, inserting pred_slot_valid, only if some cond hit exists at or before the chosen slot (or in any slot when none is taken).
  - Chosen slot is a call: push slot_pc+4 at ras_ptr; ras_ptr+1 (wraps mod RAS_DEPTH); ras_cnt saturates at RAS_DEPTH; overflow overwrites the oldest entry.
  - Chosen slot is a ret with ras_cnt>0: ras_ptr-1 (wraps), ras_cnt-1.
  - Chosen slot is a ret with ras_cnt==0: no change.
- **Redirect.** Highest priority; no lookup is accepted that cycle.
  - Next cycle pred_valid_o=0, dropping any held prediction.
  - GHR = ckpt.ghr, shifted by redirect_taken_i if redirect_is_cond_i.
  - ras_ptr and ras_cnt are restored from the checkpoint.
  - RAS[ckpt.ras_ptr-1] is rewritten with ckpt.ras_top when ckpt.ras_cnt>0.
  - The resolving call/ret is then applied by the push/pop rules above; a call pushes redirect_pc_i+4.
- **Update.** Touches only the BTB and BHT, and is independent of any same-cycle redirect or lookup (lookup sees pre-update tables).
  - BHT index uses update_ghr_i.
  - cond: 2-bit saturating increment when taken, decrement otherwise.
  - BTB write when the type is not cond, or when it is cond and taken:
    - A hitting way is overwritten in place.
    - Otherwise the set's victim way is written and the victim pointer increments, wrapping modulo BTB_WAYS.

Optional Feature:
BPU_PERF_CNT_EN.
- Defined: adds outputs perf_lookup_o[31:0] (accepted lookups) and perf_redirect_o[31:0] (redirect cycles). Both reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then lookup PC 0x8000_0000 with empty tables -> pred_slot_valid_o=0, pred_npc_o=0x8000_0010, pred_ckpt_o=0.
- Update jump PC 0x8000_0008, target 0x8000_0100, then lookup 0x8000_0000 -> slot_idx=2, npc=0x8000_0100.
- Call trained at 0x8000_0004, ret trained at 0x8000_0200. Lookup 0x8000_0000, then 0x8000_0200 -> second npc=0x8000_0008, ras_cnt returns to 0.
- Cond at 0x8000_0000 updated taken twice with ghr=0 -> with GHR=0 predicted taken. Cond hit in block -> next pred_ckpt_o ghr=0x01.
- Hold pred_ready_i=0 for 3 cycles -> outputs stable, fetch_ready_o=0. Assert redirect with ckpt ghr=0x05, cond taken -> pred_valid_o=0 next cycle, GHR=0x0B.
- 17 calls with RAS_DEPTH=16 -> ras_cnt=16, the 17th push overwrites the first. Three-way set conflict on a 2-way set -> the way 0 entry is evicted first.
